// File: rtl/oam_dma_engine_if.sv
// +----------------------------------------------------------------------------+
// | oam_dma_engine_if : CPU register port and bus-master port of the OAM DMA    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface oam_dma_engine_if;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_we;
  logic        reg_re;
  logic [7:0]  reg_rdata;
  logic        reg_hit;
  logic        m_req;
  logic        m_gnt;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata;
  logic [7:0]  m_rdata;
  logic        m_rd;
  logic        m_wr;

  // DMA engine view
  modport master (
    input  reg_addr, reg_wdata, reg_we, reg_re, m_gnt, m_rdata,
    output reg_rdata, reg_hit, m_req, m_addr, m_wdata, m_rd, m_wr
  );

  // Host / CPU / bus-fabric view
  modport slave (
    output reg_addr, reg_wdata, reg_we, reg_re, m_gnt, m_rdata,
    input  reg_rdata, reg_hit, m_req, m_addr, m_wdata, m_rd, m_wr
  );
endinterface

`default_nettype wire

// File: rtl/oam_dma_engine.sv
// +----------------------------------------------------------------------------+
// | oam_dma_engine : DMG OAM DMA, copies XFER_LEN bytes from {V,00} into OAM    |
// | Optional done pulse: define OAM_DMA_DONE_IRQ_EN.          Rev 1.0          |
// +----------------------------------------------------------------------------+
`default_nettype none

module oam_dma_engine #(
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
  parameter logic [15:0] OAM_BASE     = 16'hFE00,
  parameter int          XFER_LEN     = 160,
  parameter int          START_DELAY  = 1
) (
  input  logic             clk,
  input  logic             reset,
  oam_dma_engine_if.master bus,
  output logic             busy
`ifdef OAM_DMA_DONE_IRQ_EN
  ,
  output logic             dma_done
`endif
);

  localparam int IDX_W = $clog2(XFER_LEN);
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(XFER_LEN - 1);
  localparam logic [3:0] C_DLY_LAST = (START_DELAY > 0) ? 4'(START_DELAY - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DELAY = 3'd1,
    S_REQ   = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [3:0]       r_dly;
  logic [7:0]       r_src_page;
  logic [7:0]       r_reg_value;
  logic             r_m_req;
  logic             r_m_rd;
  logic             r_m_wr;
  logic [15:0]      r_m_addr;
  logic [7:0]       r_m_wdata;
  logic             r_busy;

  state_t           w_state_nxt;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [3:0]       w_dly_nxt;
  logic [7:0]       w_src_nxt;
  logic [7:0]       w_reg_value_nxt;
  logic [7:0]       w_latch_nxt;
  logic [15:0]      w_addr_nxt;
  logic             w_done_nxt;
  logic             w_hit;
  logic             w_trig;

  assign w_hit         = (bus.reg_addr == DMA_REG_ADDR);
  assign w_trig        = bus.reg_we && w_hit;
  assign bus.reg_hit   = w_hit;
  assign bus.reg_rdata = (bus.reg_re && w_hit) ? r_reg_value : 8'h00;

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_dly_nxt       = r_dly;
    w_src_nxt       = r_src_page;
    w_reg_value_nxt = r_reg_value;
    w_latch_nxt     = r_m_wdata;
    w_done_nxt      = 1'b0;

    case (r_state)
      S_IDLE: ;
      S_DELAY: begin
        if (r_dly == C_DLY_LAST) begin
          w_state_nxt = S_REQ;
          w_dly_nxt   = 4'd0;
        end else begin
          w_dly_nxt   = r_dly + 4'd1;
        end
      end
      S_REQ: begin
        if (bus.m_gnt) w_state_nxt = S_READ;
      end
      S_READ: begin
        w_latch_nxt = bus.m_rdata;
        w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        if (r_idx == C_IDX_LAST) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_idx_nxt   = r_idx + 1'b1;
          w_state_nxt = bus.m_gnt ? S_READ : S_REQ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // A trigger overrides whatever the sequencer chose, dropping an in-flight byte.
    if (w_trig) begin
      w_reg_value_nxt = bus.reg_wdata;
      w_src_nxt       = (bus.reg_wdata >= 8'hE0) ? (bus.reg_wdata - 8'h20) : bus.reg_wdata;
      w_idx_nxt       = '0;
      w_dly_nxt       = 4'd0;
      w_state_nxt     = (START_DELAY == 0) ? S_REQ : S_DELAY;
    end

    // Master outputs are precomputed from next-state so they leave flops directly.
    case (w_state_nxt)
      S_READ:  w_addr_nxt = {w_src_nxt, 8'h00} + 16'(w_idx_nxt);
      S_WRITE: w_addr_nxt = OAM_BASE + 16'(w_idx_nxt);
      default: w_addr_nxt = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_dly       <= 4'd0;
      r_src_page  <= 8'h00;
      r_reg_value <= 8'hFF;
      r_m_req     <= 1'b0;
      r_m_rd      <= 1'b0;
      r_m_wr      <= 1'b0;
      r_m_addr    <= 16'h0000;
      r_m_wdata   <= 8'h00;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_dly       <= w_dly_nxt;
      r_src_page  <= w_src_nxt;
      r_reg_value <= w_reg_value_nxt;
      r_m_req     <= (w_state_nxt == S_REQ) || (w_state_nxt == S_READ) ||
                     (w_state_nxt == S_WRITE);
      r_m_rd      <= (w_state_nxt == S_READ);
      r_m_wr      <= (w_state_nxt == S_WRITE);
      r_m_addr    <= w_addr_nxt;
      r_m_wdata   <= w_latch_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  assign bus.m_req   = r_m_req;
  assign bus.m_rd    = r_m_rd;
  assign bus.m_wr    = r_m_wr;
  assign bus.m_addr  = r_m_addr;
  assign bus.m_wdata = r_m_wdata;
  assign busy        = r_busy;

`ifdef OAM_DMA_DONE_IRQ_EN
  logic r_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_done <= 1'b0;
    else       r_done <= w_done_nxt;
  end

  assign dma_done = r_done;
`else
  logic w_done_unused;
  assign w_done_unused = w_done_nxt;
`endif

endmodule

`default_nettype wire
